// File: rtl/mux_nx1_rr.sv
// Registered N-channel mux with per-channel valid/ready, fixed-select or round-robin grant.
// Optional packet lock (in_last/out_last, IDLE/LOCKED) enabled by defining MUX_LOCK_EN.
module mux_nx1_rr #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
`ifdef MUX_LOCK_EN
  input  logic [N_CH-1:0]          in_last,
  output logic                     out_last,
`endif
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
);

  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              load_en, xfer;
  logic              arb_vld, grant_vld, grant_last;
  logic [SEL_W-1:0]  arb_ch, grant_ch;
  logic [DATA_W-1:0] grant_data;
  logic [31:0]       idx;

`ifdef MUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_e;
  lock_state_e       lock_state_q, lock_state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic              out_last_q, out_last_d;
`endif

  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return (ch == SEL_W'(N_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

  // Arbitration: fixed select ignores out-of-range sel by never matching it.
  always_comb begin
    arb_vld = 1'b0;
    arb_ch  = '0;
    idx     = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          arb_vld = 1'b1;
          arb_ch  = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!arb_vld && in_valid[idx[SEL_W-1:0]]) begin
          arb_vld = 1'b1;
          arb_ch  = idx[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_vld = arb_vld;
    grant_ch  = arb_ch;
`ifdef MUX_LOCK_EN
    if (lock_state_q == LOCKED) begin
      grant_ch  = lock_ch_q;
      grant_vld = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (lock_ch_q == SEL_W'(i) && in_valid[i]) grant_vld = 1'b1;
      end
    end
`endif
    grant_data = '0;
    grant_last = 1'b1;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_ch == SEL_W'(i)) begin
        grant_data = in_data[i*DATA_W +: DATA_W];
`ifdef MUX_LOCK_EN
        grant_last = in_last[i];
`endif
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = grant_vld && load_en;

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      in_ready[i] = xfer && (grant_ch == SEL_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_ch_d   = grant_ch;
      end
    end
    if (xfer && grant_last && mode) rr_ptr_d = next_ch(grant_ch);
  end

`ifdef MUX_LOCK_EN
  always_comb begin
    lock_state_d = lock_state_q;
    lock_ch_d    = lock_ch_q;
    out_last_d   = out_last_q;
    if (xfer) out_last_d = grant_last;
    if (xfer) begin
      if (lock_state_q == IDLE && !grant_last) begin
        lock_state_d = LOCKED;
        lock_ch_d    = grant_ch;
      end else if (lock_state_q == LOCKED && grant_last) begin
        lock_state_d = IDLE;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      rr_ptr_q     <= '0;
`ifdef MUX_LOCK_EN
      lock_state_q <= IDLE;
      lock_ch_q    <= '0;
      out_last_q   <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      rr_ptr_q     <= rr_ptr_d;
`ifdef MUX_LOCK_EN
      lock_state_q <= lock_state_d;
      lock_ch_q    <= lock_ch_d;
      out_last_q   <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
`ifdef MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: 4-channel scoreboard run, 3-channel out-of-range select, and packet lock when MUX_LOCK_EN is defined.
module tb_mux_nx1_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] in_data   = '0;
  logic [3:0]  in_valid  = '0;
  logic [3:0]  in_ready;
  logic        mode      = 1'b0;
  logic [1:0]  sel       = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_ch;

  logic [23:0] in_data3   = '0;
  logic [2:0]  in_valid3  = '0;
  logic [2:0]  in_ready3;
  logic        mode3      = 1'b0;
  logic [1:0]  sel3       = '0;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [1:0]  out_ch3;

`ifdef MUX_LOCK_EN
  logic [3:0]  in_last   = '1;
  logic        out_last;
  logic [2:0]  in_last3  = '1;
  logic        out_last3;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [9:0]  sb_q[$];
  logic        m_ov  = 1'b0;
  logic [7:0]  m_od  = '0;
  logic [1:0]  m_oc  = '0;
  int unsigned m_ptr = 0;

  always #5 clk = ~clk;

  mux_nx1_rr #(.N_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  mux_nx1_rr #(.N_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
`ifdef MUX_LOCK_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .mode(mode3), .sel(sel3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the 4-channel DUT against the reference model and scoreboard.
  task automatic step();
    logic        le, gv;
    logic [1:0]  g;
    logic [3:0]  exp_rdy;
    logic [9:0]  e;
    int unsigned c;
    #1;
    le = !m_ov || out_ready;
    gv = 1'b0;
    g  = '0;
    if (!mode) begin
      gv = in_valid[sel];
      g  = sel;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          g  = 2'(c);
        end
      end
    end
    exp_rdy = (le && gv) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (le && gv) begin
      sb_q.push_back({g, in_data[g*8 +: 8]});
      if (mode) m_ptr = (32'(g) + 1) % 4;
    end
    @(posedge clk);
    #1;
    if (le && gv) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      m_ov = 1'b1;
      m_oc = e[9:8];
      m_od = e[7:0];
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_ch", 32'(out_ch), 32'(m_oc));
      check("out_data", 32'(out_data), 32'(m_od));
    end else if (le) begin
      m_ov = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("out_data_hold", 32'(out_data), 32'(m_od));
      check("out_ch_hold", 32'(out_ch), 32'(m_oc));
    end else begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(m_od));
      check("stall_ch", 32'(out_ch), 32'(m_oc));
    end
  endtask

`ifdef MUX_LOCK_EN
  task automatic lock_beat(input string tag, input logic [3:0] v, input logic [3:0] last,
                           input logic [3:0] exp_rdy);
    in_valid = v;
    in_last  = last;
    #1;
    check(tag, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);

    // Fixed select of channel 2
    in_data   = {8'h13, 8'hA5, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    mode      = 1'b0;
    sel       = 2'd2;
    out_ready = 1'b1;
    step();

    // Round robin with wrap: 0,1,2,3,0
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    mode    = 1'b1;
    repeat (5) step();

    // Backpressure then release
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    step();

    // Randomised traffic
    for (int unsigned n = 0; n < 60; n++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    step();

    // Three channels: sel=3 is out of range and never grants
    in_data3   = {8'h33, 8'h22, 8'h11};
    in_valid3  = 3'b111;
    mode3      = 1'b0;
    sel3       = 2'd1;
    out_ready3 = 1'b1;
    #1;
    check("n3_in_ready_sel1", 32'(in_ready3), 32'b010);
    @(posedge clk);
    #1;
    check("n3_out_valid_sel1", 32'(out_valid3), 32'd1);
    check("n3_out_data_sel1", 32'(out_data3), 32'h22);
    sel3 = 2'd3;
    #1;
    check("n3_in_ready_sel3", 32'(in_ready3), 32'b000);
    @(posedge clk);
    #1;
    check("n3_out_valid_sel3", 32'(out_valid3), 32'd0);
    check("n3_out_data_hold", 32'(out_data3), 32'h22);

`ifdef MUX_LOCK_EN
    in_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_data   = {8'h43, 8'h42, 8'h41, 8'h40};
    lock_beat("lk_a_rdy", 4'b0001, 4'b1111, 4'b0001);
    check("lk_a_ch", 32'(out_ch), 32'd0);
    lock_beat("lk_b_rdy", 4'b0111, 4'b1101, 4'b0010);
    check("lk_b_ch", 32'(out_ch), 32'd1);
    check("lk_b_last", 32'(out_last), 32'd0);
    lock_beat("lk_wait_rdy", 4'b0101, 4'b1101, 4'b0000);
    check("lk_wait_valid", 32'(out_valid), 32'd0);
    lock_beat("lk_d_rdy", 4'b0111, 4'b1101, 4'b0010);
    check("lk_d_ch", 32'(out_ch), 32'd1);
    lock_beat("lk_e_rdy", 4'b0111, 4'b1111, 4'b0010);
    check("lk_e_ch", 32'(out_ch), 32'd1);
    check("lk_e_last", 32'(out_last), 32'd1);
    lock_beat("lk_f_rdy", 4'b0111, 4'b1111, 4'b0100);
    check("lk_f_ch", 32'(out_ch), 32'd2);
    lock_beat("lk_g_rdy", 4'b0010, 4'b1101, 4'b0010);
    in_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("lk_rst_last", 32'(out_last), 32'd0);
    lock_beat("lk_rearb_rdy", 4'b0111, 4'b1101, 4'b0001);
    check("lk_rearb_ch", 32'(out_ch), 32'd0);
    in_valid = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
